sid_audio_decim: RTL and testbench
==================================

Name: sid_audio_decim

Overview:
Downstream stage of the SID core. It consumes the 18-bit signed mixer/DAC output, which updates at the 1 MHz core rate. The samples are low-pass filtered with a 2^LOG2N-tap moving-average (boxcar). The filtered value is captured on each output-rate strobe and queued in a small FWFT FIFO with a valid/ready handshake toward the audio output path.

Parameters:
LOG2N, 5, log2 of boxcar length; 32 taps by default; legal range 1..8
FIFO_AW, 2, log2 of output FIFO depth; 4 entries by default
DC_SHIFT, 10, DC-blocker pole shift; used only when SID_DECIM_DCBLOCK_EN is defined

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  input sample strobe (core 1 MHz enable)
audio_in  in  18  signed input sample
out_strobe  in  1  output-rate tick, one clk wide, already synchronous to clk
out_data  out  18  signed FIFO head sample
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts head this cycle
overflow  out  1  sticky; a strobe found the FIFO full
clr_overflow  in  1  clears overflow

Behaviour:
- Reset and clocking: one clock (clk); reset_n is asynchronous and active-low.
- Reset values: out_data=0, out_valid=0, overflow=0. Running sum, write index, fill counter and FIFO pointers are all 0.
- Delay line: 2^LOG2N x 18 memory, not cleared by reset.
  - A fill counter (LOG2N+1 bits, saturates at 2^LOG2N) marks which slots are valid.
  - Until the line is full, the subtracted old value is forced to 0.
- Boxcar update on in_valid:
  - sum <= sum + audio_in - old, where old = fill full ? line[wr_idx] : 0.
  - line[wr_idx] <= audio_in; wr_idx increments and wraps modulo 2^LOG2N.
  - sum is signed, 18+LOG2N bits, and never overflows.
- avg = sum >>> LOG2N (arithmetic shift, truncation toward -inf), 18 bits. During fill the divisor is still 2^LOG2N, so avg ramps up.
- Capture: out_strobe in cycle t samples the registered sum as it stands in cycle t. An in_valid in the same cycle is not included.
- Push: the captured value is pushed in cycle t+1. With an empty FIFO, out_valid=1 and out_data=value from t+1 onward.
- FIFO (first-word fall-through): out_data always shows the head. A pop occurs when out_valid & out_ready.
- Push while full:
  - Without a same-cycle pop: sample dropped, overflow <= 1.
  - With a same-cycle pop: push accepted, no overflow.
- Push and pop on an empty FIFO cannot coincide, because out_valid=0.
- out_ready is ignored while out_valid=0. out_data holds its last value when the FIFO is empty.
- overflow: set has priority over clr_overflow in the same cycle.
- Reset mid-operation: async assert immediately zeroes outputs and pointers. After release, behaviour is as from power-up, including the fill counter.
- in_valid and out_strobe may coincide, or arrive back-to-back on consecutive cycles; both are handled every cycle with no stall.

Optional Feature:
SID_DECIM_DCBLOCK_EN:
- When defined, a first-order DC blocker sits between capture and push.
- Transfer: y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT).
- Internal y is 18+DC_SHIFT bits with DC_SHIFT fraction bits. It updates once per out_strobe.
- Output is y rounded toward -inf and saturated to [-131072, 131071].
- Adds one cycle: push happens at t+2.
- x_prev and y reset to 0.
- When not defined: no blocker, push at t+1, and DC_SHIFT is unused.

Test Plan:
- Fill and steady state: audio_in=1000 for 16 in_valids, then out_strobe -> out_data=500. After 32+ in_valids, out_strobe -> out_data=1000, out_valid rises exactly 1 cycle after the strobe.
- Extremes: audio_in=-131072 for 64 samples, then strobe -> out_data=-131072. Switch to 131071 for 32 samples, then strobe -> out_data=131071, with no wrap.
- Overflow: out_ready=0, 5 out_strobes -> 4 entries queued, overflow=1, first 4 values preserved in order. Strobe plus clr_overflow in the same cycle -> overflow stays 1.
- Full push+pop: FIFO full, out_ready=1 and out_strobe in the same cycle -> count stays 4, overflow stays 0, new value appears last.
- Coincident events: in_valid(new sample 2000) and out_strobe in the same cycle after steady 1000 -> captured value 1000, and the next strobe reflects (31*1000+2000)>>5=1031.
- Reset mid-fill: deassert reset_n after 20 samples of 1000, then feed 8 samples of 1000 and strobe -> out_data=250. With SID_DECIM_DCBLOCK_EN, a constant 1000 gives a first output of 1000 that decays monotonically toward 0.

Source files
------------

// File: rtl/sid_audio_decim_if.sv
// Sample-stream bundle between the SID mixer output, the decimator and the audio path.
// The master drives samples, strobes and the consumer side; the slave is the decimator.
interface sid_audio_decim_if;
  logic               in_valid;
  logic signed [17:0] audio_in;
  logic               out_strobe;
  logic signed [17:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               overflow;
  logic               clr_overflow;

  modport master (
    output in_valid, audio_in, out_strobe, out_ready, clr_overflow,
    input  out_data, out_valid, overflow
  );

  modport slave (
    input  in_valid, audio_in, out_strobe, out_ready, clr_overflow,
    output out_data, out_valid, overflow
  );
endinterface

// File: rtl/sid_audio_decim.sv
// Boxcar low-pass of the 1 MHz SID output, decimated on out_strobe into a FWFT FIFO.
// Optional DC blocker between capture and push when SID_DECIM_DCBLOCK_EN is defined.
module sid_audio_decim #(
  parameter int LOG2N    = 5,
  parameter int FIFO_AW  = 2,
  parameter int DC_SHIFT = 10
) (
  input logic               clk,
  input logic               reset_n,
  sid_audio_decim_if.slave  bus
);
  localparam int N     = 1 << LOG2N;
  localparam int SW    = 18 + LOG2N;
  localparam int DEPTH = 1 << FIFO_AW;

  logic signed [17:0]    line_mem [N];
  logic [LOG2N-1:0]      wr_idx_q, wr_idx_d;
  logic [LOG2N:0]        fill_q, fill_d;
  logic signed [SW-1:0]  sum_q, sum_d, old_s, sum_shr_s;
  logic signed [17:0]    avg_s;
  logic                  line_full_s;

  logic                  push_s;
  logic signed [17:0]    push_data_s;

  logic signed [17:0]    fifo_mem [DEPTH];
  logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]      count_q, count_d, remain_s;
  logic                  out_valid_q, out_valid_d;
  logic signed [17:0]    out_data_q, out_data_d;
  logic                  ovf_q, ovf_d;
  logic                  pop_s, full_s, push_ok_s;

  // Running boxcar sum; the subtracted tap is zero until the delay line has filled once.
  always_comb begin
    line_full_s = (fill_q == (LOG2N+1)'(N));
    old_s       = line_full_s ? {{LOG2N{line_mem[wr_idx_q][17]}}, line_mem[wr_idx_q]} : '0;
    sum_d       = sum_q;
    wr_idx_d    = wr_idx_q;
    fill_d      = fill_q;
    if (bus.in_valid) begin
      sum_d    = sum_q + {{LOG2N{bus.audio_in[17]}}, bus.audio_in} - old_s;
      wr_idx_d = wr_idx_q + 1'b1;
      fill_d   = line_full_s ? fill_q : fill_q + 1'b1;
    end else begin
      sum_d    = sum_q;
    end
    sum_shr_s = sum_q >>> LOG2N;
    avg_s     = sum_shr_s[17:0];
  end

  // Delay line storage, deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (bus.in_valid) line_mem[wr_idx_q] <= bus.audio_in;
  end

`ifdef SID_DECIM_DCBLOCK_EN
  localparam int YW = 18 + DC_SHIFT;
  localparam int WW = YW + 2;
  localparam logic signed [WW-1:0] Y_MAX = {3'b000, {(YW-1){1'b1}}};
  localparam logic signed [WW-1:0] Y_MIN = {3'b111, {(YW-1){1'b0}}};

  logic signed [17:0]   x_prev_q, x_prev_d;
  logic signed [YW-1:0] y_q, y_d;
  logic                 dc_vld_q, dc_vld_d;
  logic signed [WW-1:0] y_new_s;

  // One-pole DC blocker in DC_SHIFT-bit fixed point, saturated to the 18-bit integer range.
  always_comb begin
    y_new_s  = ((WW'(avg_s) - WW'(x_prev_q)) <<< DC_SHIFT) + WW'(y_q) - WW'(y_q >>> DC_SHIFT);
    y_d      = y_q;
    x_prev_d = x_prev_q;
    dc_vld_d = 1'b0;
    if (bus.out_strobe) begin
      x_prev_d = avg_s;
      dc_vld_d = 1'b1;
      if (y_new_s > Y_MAX)      y_d = Y_MAX[YW-1:0];
      else if (y_new_s < Y_MIN) y_d = Y_MIN[YW-1:0];
      else                      y_d = y_new_s[YW-1:0];
    end else begin
      dc_vld_d = 1'b0;
    end
    push_s      = dc_vld_q;
    push_data_s = y_q[YW-1:DC_SHIFT];
  end

  // Blocker state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_prev_q <= '0;
      y_q      <= '0;
      dc_vld_q <= 1'b0;
    end else begin
      x_prev_q <= x_prev_d;
      y_q      <= y_d;
      dc_vld_q <= dc_vld_d;
    end
  end
`else
  logic unused_dc_shift_s;
  assign unused_dc_shift_s = ^DC_SHIFT;

  // Without the blocker the strobe pushes the current average directly.
  always_comb begin
    push_s      = bus.out_strobe;
    push_data_s = avg_s;
  end
`endif

  // FIFO control; a full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    pop_s     = out_valid_q & bus.out_ready;
    full_s    = (count_q == (FIFO_AW+1)'(DEPTH));
    push_ok_s = push_s & (~full_s | pop_s);
    rd_ptr_d  = pop_s     ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d  = push_ok_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
    remain_s  = pop_s     ? count_q - 1'b1  : count_q;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    out_valid_d = (count_d != '0);
    if (count_d == '0)       out_data_d = out_data_q;
    else if (remain_s == '0) out_data_d = push_data_s;
    else                     out_data_d = fifo_mem[rd_ptr_d];
    if (push_s & full_s & ~pop_s) ovf_d = 1'b1;
    else if (bus.clr_overflow)    ovf_d = 1'b0;
    else                          ovf_d = ovf_q;
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_ok_s) fifo_mem[wr_ptr_q] <= push_data_s;
  end

  // Filter and FIFO state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q       <= '0;
      wr_idx_q    <= '0;
      fill_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      wr_idx_q    <= wr_idx_d;
      fill_q      <= fill_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_sid_audio_decim.sv
// Directed bench for sid_audio_decim; expectations are hand-computed boxcar/FIFO values.
// With SID_DECIM_DCBLOCK_EN defined it runs the DC-blocker decay sequence instead.
module tb_sid_audio_decim;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  sid_audio_decim_if bus();

  sid_audio_decim dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.audio_in = 18'(v);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic strobe();
    bus.out_strobe = 1'b1;
    tick();
    bus.out_strobe = 1'b0;
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.audio_in     = '0;
    bus.out_strobe   = 1'b0;
    bus.out_ready    = 1'b0;
    bus.clr_overflow = 1'b0;
    tick();
    tick();
    check_eq("rst_valid", int'(bus.out_valid), 0);
    check_eq("rst_data", int'(bus.out_data), 0);
    check_eq("rst_ovf", int'(bus.overflow), 0);
    reset_n = 1'b1;
    tick();

`ifdef SID_DECIM_DCBLOCK_EN
    feed(1000, 32);
    strobe();
    check_eq("dc_valid_t1", int'(bus.out_valid), 0);
    tick();
    check_eq("dc_valid_t2", int'(bus.out_valid), 1);
    check_eq("dc_first", int'(bus.out_data), 1000);
    pop();
    strobe();
    tick();
    check_eq("dc_second", int'(bus.out_data), 999);
    pop();
    strobe();
    tick();
    check_eq("dc_third", int'(bus.out_data), 998);
    pop();
`else
    // Half-filled line: 16*1000/32
    feed(1000, 16);
    bus.out_strobe = 1'b1;
    check_eq("valid_before_push", int'(bus.out_valid), 0);
    tick();
    bus.out_strobe = 1'b0;
    check_eq("valid_t1", int'(bus.out_valid), 1);
    check_eq("fill_half", int'(bus.out_data), 500);
    pop();
    check_eq("empty_after_pop", int'(bus.out_valid), 0);
    check_eq("data_hold", int'(bus.out_data), 500);

    feed(1000, 32);
    strobe();
    check_eq("steady", int'(bus.out_data), 1000);
    pop();

    // Coincident sample and strobe: capture excludes the new sample
    bus.in_valid   = 1'b1;
    bus.audio_in   = 18'(2000);
    bus.out_strobe = 1'b1;
    tick();
    bus.in_valid   = 1'b0;
    bus.out_strobe = 1'b0;
    strobe();
    check_eq("coinc_first", int'(bus.out_data), 1000);
    pop();
    check_eq("coinc_second", int'(bus.out_data), 1031);
    pop();
    check_eq("coinc_empty", int'(bus.out_valid), 0);

    feed(-131072, 64);
    strobe();
    check_eq("min_extreme", int'(bus.out_data), -131072);
    pop();
    feed(131071, 32);
    strobe();
    check_eq("max_extreme", int'(bus.out_data), 131071);
    pop();

    // Overflow: four distinct entries, fifth strobe dropped
    for (int k = 1; k <= 5; k++) begin
      feed(k * 100, 32);
      strobe();
    end
    check_eq("ovf_set", int'(bus.overflow), 1);
    bus.clr_overflow = 1'b1;
    strobe();
    bus.clr_overflow = 1'b0;
    check_eq("ovf_set_beats_clr", int'(bus.overflow), 1);
    for (int k = 1; k <= 4; k++) begin
      check_eq("ovf_order", int'(bus.out_data), k * 100);
      pop();
    end
    check_eq("ovf_drained", int'(bus.out_valid), 0);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    check_eq("ovf_clr", int'(bus.overflow), 0);

    // Full FIFO with simultaneous push and pop
    for (int k = 0; k < 4; k++) strobe();
    feed(600, 32);
    bus.out_ready  = 1'b1;
    bus.out_strobe = 1'b1;
    tick();
    bus.out_ready  = 1'b0;
    bus.out_strobe = 1'b0;
    check_eq("pp_no_ovf", int'(bus.overflow), 0);
    for (int k = 0; k < 3; k++) begin
      check_eq("pp_old", int'(bus.out_data), 500);
      pop();
    end
    check_eq("pp_new_last", int'(bus.out_data), 600);
    pop();
    check_eq("pp_count4", int'(bus.out_valid), 0);

    // Reset mid-fill restarts the fill counter
    feed(1000, 20);
    strobe();
    check_eq("pre_reset_valid", int'(bus.out_valid), 1);
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_valid", int'(bus.out_valid), 0);
    check_eq("async_rst_data", int'(bus.out_data), 0);
    tick();
    reset_n = 1'b1;
    tick();
    feed(1000, 8);
    strobe();
    check_eq("refill_quarter", int'(bus.out_data), 250);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
